// File: rtl/fifo_write_controller_if.sv
// fifo_write_controller_if: write-side bus of the dual-clock FIFO.
// Ports: din/din_send/din_ack (producer handshake), din_rdy (room, from flags),
// mem_we/mem_addr/mem_data (memory write), wr_address (Gray write pointer),
// wr_stall_cnt (stall statistics). master = controller, slave = its peers.
interface fifo_write_controller_if #(parameter int depth = 8, parameter int width = 8);
  logic [width-1:0] din;
  logic             din_send;
  logic             din_ack;
  logic             din_rdy;
  logic             mem_we;
  logic [depth-1:0] mem_addr;
  logic [width-1:0] mem_data;
  logic [depth-1:0] wr_address;
  logic [15:0]      wr_stall_cnt;
  modport master (input din, din_send, din_rdy,
                  output din_ack, mem_we, mem_addr, mem_data, wr_address, wr_stall_cnt);
  modport slave (output din, din_send, din_rdy,
                 input din_ack, mem_we, mem_addr, mem_data, wr_address, wr_stall_cnt);
endinterface

// File: rtl/fifo_write_controller.sv
// fifo_write_controller: write-domain FIFO controller with 2-entry skid buffer and Gray pointer.
// Ports: din_clock (write clock), reset_n (async active-low), bus (fifo_write_controller_if.master).
// Optional macro FIFO_WR_STALL_STATS_EN enables the saturating wr_stall_cnt counter.
module fifo_write_controller #(parameter int depth = 8, parameter int width = 8) (
  input logic din_clock,
  input logic reset_n,
  fifo_write_controller_if.master bus
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} occ_t;
  occ_t             occ_q, occ_d;
  logic [width-1:0] e0_q, e0_d, e1_q, e1_d;
  logic             ack_q, ack_d;
  logic [depth-1:0] ptr_q, ptr_d, gray_q, gray_d;
  logic             push, pop;
  assign push = bus.din_send & ack_q;
  assign pop  = (occ_q != EMPTY) & bus.din_rdy;
  always_comb begin
    occ_d = occ_q;
    e0_d  = e0_q;
    e1_d  = e1_q;
    case (occ_q)
      EMPTY: if (push) begin
        occ_d = ONE;
        e0_d  = bus.din;
      end
      ONE: if (push && !pop) begin
        occ_d = FULL;
        e1_d  = bus.din;
      end else if (pop && !push) occ_d = EMPTY;
      else if (push) e0_d = bus.din;
      FULL: if (pop) begin
        occ_d = ONE;
        e0_d  = e1_q;
      end
      default: occ_d = EMPTY;
    endcase
    ack_d  = occ_d != FULL;
    ptr_d  = ptr_q + depth'(pop);
    gray_d = ptr_d ^ (ptr_d >> 1);
  end
  always_ff @(posedge din_clock or negedge reset_n)
    if (!reset_n) begin
      occ_q  <= EMPTY;
      e0_q   <= '0;
      e1_q   <= '0;
      ack_q  <= 1'b0;
      ptr_q  <= '0;
      gray_q <= '0;
    end else begin
      occ_q  <= occ_d;
      e0_q   <= e0_d;
      e1_q   <= e1_d;
      ack_q  <= ack_d;
      ptr_q  <= ptr_d;
      gray_q <= gray_d;
    end
  assign bus.din_ack    = ack_q;
  assign bus.mem_we     = pop;
  assign bus.mem_addr   = ptr_q;
  assign bus.mem_data   = e0_q;
  assign bus.wr_address = gray_q;
`ifdef FIFO_WR_STALL_STATS_EN
  logic [15:0] stall_q, stall_d;
  assign stall_d = (occ_q != EMPTY && !bus.din_rdy && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
  always_ff @(posedge din_clock or negedge reset_n)
    if (!reset_n) stall_q <= 16'h0000;
    else stall_q <= stall_d;
  assign bus.wr_stall_cnt = stall_q;
`else
  assign bus.wr_stall_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_fifo_write_controller.sv
// tb_fifo_write_controller: directed scoreboard bench for fifo_write_controller.
module tb_fifo_write_controller;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;
  fifo_write_controller_if #(.depth(8), .width(8)) b8();
  fifo_write_controller_if #(.depth(3), .width(8)) b3();
  fifo_write_controller #(.depth(8), .width(8)) dut8 (.din_clock(clk), .reset_n(reset_n), .bus(b8));
  fifo_write_controller #(.depth(3), .width(8)) dut3 (.din_clock(clk), .reset_n(reset_n), .bus(b3));
  int n_assert = 0;
  int n_fail = 0;
  int writes = 0;
  logic [15:0] sb[$];
  logic [7:0] exp_ptr = 8'd0;
  function automatic logic [7:0] gray(input logic [7:0] v);
    return v ^ (v >> 1);
  endfunction
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic mid;
    @(negedge clk);
  endtask
  task automatic expect_word(input logic [7:0] d);
    sb.push_back({exp_ptr, d});
    exp_ptr++;
  endtask
  always @(negedge clk)
    if (reset_n && b8.mem_we === 1'b1) begin
      logic [15:0] e;
      writes++;
      check("sb_empty_at_write", 32'(sb.size() == 0), 0);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("wr_addr", b8.mem_addr, e[15:8]);
        check("wr_data", b8.mem_data, e[7:0]);
        check("wr_gray", b8.wr_address, gray(e[15:8]));
      end
    end
  initial begin
    b8.din = 8'h00; b8.din_send = 1'b0; b8.din_rdy = 1'b1;
    b3.din = 8'h00; b3.din_send = 1'b0; b3.din_rdy = 1'b1;
    repeat (3) tick;
    mid;
    check("rst_ack", b8.din_ack, 0);
    check("rst_we", b8.mem_we, 0);
    check("rst_addr", b8.mem_addr, 0);
    check("rst_gray", b8.wr_address, 0);
    check("rst_data", b8.mem_data, 0);
    check("rst_stall", b8.wr_stall_cnt, 0);
    reset_n = 1'b1;
    #1 check("ack_before_edge", b8.din_ack, 0);
    tick;
    check("ack_after_release", b8.din_ack, 1);
    for (int i = 0; i < 4; i++) begin
      b8.din = 8'hA1 + 8'(i);
      b8.din_send = 1'b1;
      expect_word(b8.din);
      mid;
      check("stream_ack", b8.din_ack, 1);
      tick;
    end
    b8.din_send = 1'b0;
    tick;
    tick;
    mid;
    check("stream_gray_end", b8.wr_address, 8'h06);
    check("stream_writes", writes, 4);
    check("stream_sb_drained", sb.size(), 0);
    check("stream_idle_we", b8.mem_we, 0);
    tick;
    b8.din_rdy = 1'b0;
    b8.din = 8'hB0; b8.din_send = 1'b1;
    expect_word(8'hB0);
    mid;
    check("bp_ack0", b8.din_ack, 1);
    tick;
    b8.din = 8'hB1;
    expect_word(8'hB1);
    mid;
    check("bp_ack1", b8.din_ack, 1);
    check("bp_we1", b8.mem_we, 0);
    tick;
    b8.din = 8'hB2;
    mid;
    check("bp_ack_full", b8.din_ack, 0);
    check("bp_we2", b8.mem_we, 0);
    tick;
    mid;
    check("bp_ack_full2", b8.din_ack, 0);
    check("bp_we3", b8.mem_we, 0);
    tick;
    b8.din_send = 1'b0;
    b8.din_rdy = 1'b1;
    mid;
    check("bp_ack_first_write", b8.din_ack, 0);
    tick;
    mid;
    check("bp_ack_restored", b8.din_ack, 1);
    tick;
    mid;
    check("bp_we_after", b8.mem_we, 0);
    check("bp_sb_drained", sb.size(), 0);
    check("bp_writes", writes, 6);
    tick;
    for (int k = 0; k < 10; k++) begin
      if (k < 9) begin
        b3.din = 8'h30 + 8'(k);
        b3.din_send = 1'b1;
      end else b3.din_send = 1'b0;
      mid;
      if (k < 9) check("wrap_ack", b3.din_ack, 1);
      if (k > 0) begin
        check("wrap_we", b3.mem_we, 1);
        check("wrap_addr", b3.mem_addr, (k - 1) % 8);
        check("wrap_data", b3.mem_data, 8'h30 + 8'(k - 1));
        check("wrap_gray", b3.wr_address, gray(8'((k - 1) % 8)));
      end
      tick;
    end
    mid;
    check("wrap_we_end", b3.mem_we, 0);
    check("wrap_gray_end", b3.wr_address, 1);
    tick;
    b8.din_rdy = 1'b0;
    b8.din = 8'hC0; b8.din_send = 1'b1;
    tick;
    b8.din = 8'hC1;
    tick;
    b8.din_send = 1'b0;
    mid;
    check("mr_full_ack", b8.din_ack, 0);
    tick;
    b8.din_rdy = 1'b1;
    #1 check("mr_we_before", b8.mem_we, 1);
    reset_n = 1'b0;
    #1;
    check("mr_we", b8.mem_we, 0);
    check("mr_gray", b8.wr_address, 0);
    check("mr_ack", b8.din_ack, 0);
    check("mr_addr", b8.mem_addr, 0);
    check("mr_data", b8.mem_data, 0);
    sb.delete();
    exp_ptr = 8'd0;
    tick;
    reset_n = 1'b1;
    tick;
    b8.din = 8'hD0; b8.din_send = 1'b1;
    expect_word(8'hD0);
    mid;
    check("mr_ack_after", b8.din_ack, 1);
    tick;
    b8.din_send = 1'b0;
    tick;
    b8.din_rdy = 1'b0;
    b8.din = 8'hE0; b8.din_send = 1'b1;
    expect_word(8'hE0);
    tick;
    b8.din_send = 1'b0;
    repeat (70000) @(posedge clk);
    mid;
`ifdef FIFO_WR_STALL_STATS_EN
    check("stall_cnt", b8.wr_stall_cnt, 16'hFFFF);
`else
    check("stall_cnt", b8.wr_stall_cnt, 16'h0000);
`endif
    check("stall_we", b8.mem_we, 0);
    tick;
    b8.din_rdy = 1'b1;
    tick;
    tick;
    mid;
    check("final_sb_drained", sb.size(), 0);
    check("final_writes", writes, 8);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
